seg_scan_rx: RTL and testbench
==============================

Name: seg_scan_rx

Overview:
Receive-side monitor for the six-digit multiplexed seven-segment bus: segments a..g, dp, and a 6-bit active-low digit enable.
It samples each digit once its enable and segment lines have settled, and decodes each segment pattern back to a BCD digit.
It assembles the six digits into a frame and publishes each complete, in-order scan.
It is used as a display loopback checker and to read the display bus back in board-level tests.

Parameters:
SETTLE_CYC, 16, number of consecutive identical synchronized input cycles required before a digit is sampled (>=2)
TIMEOUT_CYC, 100000, maximum number of clk cycles between consecutive digit samples inside a frame

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
i_seg  input  7  segments {a,b,c,d,e,f,g}, active-high, a is MSB
i_seg_dp  input  1  decimal point, active-high
i_seg_enb  input  6  digit enables, active-low one-hot; bit k low selects digit k
o_six_digit_seg  output  42  raw captured segments; digit k at [7k+6:7k]
o_six_num  output  24  decoded digits; digit k at [4k+3:4k]; 4'hF means pattern not 0-9
o_six_dp  output  6  captured dp; bit k belongs to digit k
o_frame_vld  output  1  one-cycle pulse; new frame present on the data outputs
o_frm_err  output  1  one-cycle pulse; frame aborted

Behaviour:
- All 14 inputs pass through a 2-flop synchronizer. Every later stage uses only the synchronized vector.
- Stability counter:
  - Clears to 0 when the synchronized vector differs from its value in the previous cycle; otherwise it increments, saturating.
  - A "sample event" fires exactly once per stable period, in the cycle the counter reaches SETTLE_CYC-1.
  - No further sample fires until the vector changes again.
- Enable classification at a sample event:
  - Exactly one zero: digit index k.
  - All ones: blank; the event is ignored with no state change.
  - Anything else: illegal.
- Segment decode:
  - 7'h7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 73=9.
  - Every other pattern decodes to 4'hF. This is not an error.
- FSM, two states:
  - HUNT: a sample event with k=0 writes shadow digit 0, sets expect=1, and moves to CAP. Any other k, or an illegal pattern, is ignored.
  - CAP, sample event with k==expect: write shadow digit k.
    - If k<5: expect<=k+1.
    - If k==5: commit the frame and go to HUNT.
  - CAP, sample event with k!=expect, or an illegal pattern: o_frm_err pulse and the shadow is discarded.
    - If k==0: digit 0 is written, expect=1, and the FSM stays in CAP (restart).
    - Otherwise: go to HUNT.
  - CAP timeout counter:
    - Cleared on every accepted sample.
    - When it reaches TIMEOUT_CYC: o_frm_err pulse, go to HUNT.
    - Any sample event in that same cycle is treated as arriving in HUNT.
  - Blank enable in CAP: no effect. The timeout still runs.
- Commit:
  - In the cycle after the digit-5 sample, o_six_digit_seg, o_six_num and o_six_dp load all six shadow digits, and o_frame_vld is high for that one cycle.
  - Outputs hold until the next commit. Errors never modify the data outputs.
- o_frame_vld and o_frm_err are never high in the same cycle. Both are registered outputs.
- Latency: an input change reaches the sample event SETTLE_CYC+1 cycles later (2 sync stages + settle). The commit follows one cycle after the digit-5 sample.
- Reset (any cycle, including mid-frame):
  - FSM to HUNT; expect, counters and shadow cleared.
  - o_six_digit_seg=0, o_six_num=24'hFFFFFF, o_six_dp=0, o_frame_vld=0, o_frm_err=0.
  - Synchronizer flops reset to all ones on enables and zero elsewhere. This means a stable blank after reset.

Test Plan (bench uses SETTLE_CYC=4, TIMEOUT_CYC=64):
- Reset asserted 3 cycles with random inputs -> o_six_num=24'hFFFFFF, other outputs 0, no pulses during reset or for 8 cycles after with i_seg_enb=6'h3F.
- Scan digits 0..5 with patterns {70,79,70,79,70,79}, dp=6'b000100, 10 cycles each -> single o_frame_vld, o_six_num=24'h373737, o_six_dp=6'b000100, o_six_digit_seg matches the driven values.
- During a valid scan, glitch i_seg to 7'h00 for 2 cycles mid-digit -> no extra sample, frame still valid with unchanged values.
- Drive digits 0,1,3 -> o_frm_err pulse on the digit-3 sample, no o_frame_vld; then 0..5 scan -> valid frame.
- Digits 0,1 then hold digit 1 for 80 cycles -> o_frm_err exactly one cycle, 64 cycles after the digit-1 sample; the enable 6'b111100 (illegal) held stable in CAP -> o_frm_err.
- Pattern 7'h01 on digit 2 -> frame valid with nibble 2 = 4'hF; reset during digit 3 of a scan -> no vld, previous outputs cleared to reset values.

Source files
------------

// File: rtl/seg_scan_rx.sv
// seg_scan_rx: samples a multiplexed six-digit seven-segment bus and republishes complete in-order scans
module seg_scan_rx #(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   input  logic [5:0]  i_seg_enb,
   output logic [41:0] o_six_digit_seg,
   output logic [23:0] o_six_num,
   output logic [5:0]  o_six_dp,
   output logic        o_frame_vld,
   output logic        o_frm_err
);
   localparam int CW = $clog2(SETTLE_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_HIT = CW'(SETTLE_CYC - 2);
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] TMO_HIT = TW'(TIMEOUT_CYC - 1);
   localparam logic [13:0] SYNC_RST = 14'h003F;

   typedef enum logic {HUNT, CAP} state_t;

   state_t        state_q, state_d;
   logic [13:0]   sync1_q, sync2_q, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [2:0]    exp_q, exp_d;
   logic [41:0]   shd_seg_q, shd_seg_d, dseg_q, dseg_d;
   logic [5:0]    shd_dp_q, shd_dp_d, dp_q, dp_d;
   logic [23:0]   num_q, num_d;
   logic          vld_q, vld_d, err_q, err_d;
   logic          stable, sample, blank, legal, tmo_hit, cap, ev, in_order, restart, wr, done, bad;
   logic [2:0]    k;

   function automatic logic [3:0] dec(input logic [6:0] s);
      case (s)
         7'h7E:   dec = 4'd0;
         7'h30:   dec = 4'd1;
         7'h6D:   dec = 4'd2;
         7'h79:   dec = 4'd3;
         7'h33:   dec = 4'd4;
         7'h5B:   dec = 4'd5;
         7'h5F:   dec = 4'd6;
         7'h70:   dec = 4'd7;
         7'h7F:   dec = 4'd8;
         7'h73:   dec = 4'd9;
         default: dec = 4'hF;
      endcase
   endfunction

   always_comb begin
      stable = sync2_q == prev_q;
      cnt_d = !stable ? '0 : cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
      sample = stable && cnt_q == CNT_HIT;
      blank = &sync2_q[5:0];
      legal = $onehot(~sync2_q[5:0]);
      k = '0;
      for (int i = 0; i < 6; i++) if (!sync2_q[i]) k = 3'(i);
      // a timeout in the same cycle as a sample makes that sample land in HUNT
      tmo_hit = state_q == CAP && tmo_q == TMO_HIT;
      cap = state_q == CAP && !tmo_hit;
      ev = sample && !blank;
      in_order = ev && legal && (cap ? k == exp_q : k == 3'd0);
      restart = ev && legal && cap && !in_order && k == 3'd0;
      wr = in_order || restart;
      done = in_order && cap && k == 3'd5;
      bad = ev && cap && !in_order;
      shd_seg_d = shd_seg_q;
      shd_dp_d = shd_dp_q;
      for (int i = 0; i < 6; i++) begin
         if (wr && k == 3'(i)) begin
            shd_seg_d[7*i +: 7] = sync2_q[13:7];
            shd_dp_d[i] = sync2_q[6];
         end
      end
      state_d = done ? HUNT : wr ? CAP : (bad || tmo_hit) ? HUNT : state_q;
      exp_d = wr ? k + 3'd1 : exp_q;
      tmo_d = (state_d == HUNT || wr) ? '0 : tmo_q + 1'b1;
      err_d = bad || tmo_hit;
      vld_d = done;
      dseg_d = done ? shd_seg_d : dseg_q;
      dp_d = done ? shd_dp_d : dp_q;
      num_d = num_q;
      for (int i = 0; i < 6; i++) if (done) num_d[4*i +: 4] = dec(shd_seg_d[7*i +: 7]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= SYNC_RST;
         sync2_q   <= SYNC_RST;
         prev_q    <= SYNC_RST;
         cnt_q     <= '0;
         tmo_q     <= '0;
         state_q   <= HUNT;
         exp_q     <= '0;
         shd_seg_q <= '0;
         shd_dp_q  <= '0;
         dseg_q    <= '0;
         num_q     <= '1;
         dp_q      <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= {i_seg, i_seg_dp, i_seg_enb};
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         state_q   <= state_d;
         exp_q     <= exp_d;
         shd_seg_q <= shd_seg_d;
         shd_dp_q  <= shd_dp_d;
         dseg_q    <= dseg_d;
         num_q     <= num_d;
         dp_q      <= dp_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

   assign o_six_digit_seg = dseg_q;
   assign o_six_num       = num_q;
   assign o_six_dp        = dp_q;
   assign o_frame_vld     = vld_q;
   assign o_frm_err       = err_q;
endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: directed and random scans against a cycle-level behavioural model of the receiver
module tb_seg_scan_rx;
   localparam int SETTLE = 4;
   localparam int TMO    = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  i_seg;
   logic        i_seg_dp;
   logic [5:0]  i_seg_enb;
   logic [41:0] o_six_digit_seg;
   logic [23:0] o_six_num;
   logic [5:0]  o_six_dp;
   logic        o_frame_vld;
   logic        o_frm_err;

   seg_scan_rx #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
      .o_six_digit_seg(o_six_digit_seg), .o_six_num(o_six_num), .o_six_dp(o_six_dp),
      .o_frame_vld(o_frame_vld), .o_frm_err(o_frm_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int nv = 0, ne = 0;
   logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

   function automatic logic [3:0] ref_dec(input logic [6:0] s);
      ref_dec = 4'hF;
      for (int d = 0; d < 10; d++) if (pat[d] == s) ref_dec = 4'(d);
   endfunction

   task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model: a sample fires once the raw input has been identical for SETTLE
   // consecutive clocks; its effect shows on the outputs two clocks after that run completes
   logic [41:0] e_seg;
   logic [23:0] e_num;
   logic [5:0]  e_dp, m_dp;
   logic        e_vld, e_err, pa_v, pb_v;
   logic [6:0]  m_seg [6];
   logic [13:0] lastx, x, pa, pb;
   int st, ek, last, rl, m, nz, kk;

   always @(posedge clk) begin
      m++;
      if (rst) begin
         st = 0; ek = 0; last = 0; rl = 1; lastx = 14'h003F; pa_v = 0; pb_v = 0;
         e_seg = '0; e_num = '1; e_dp = '0; e_vld = 0; e_err = 0; m_dp = '0;
         for (int i = 0; i < 6; i++) m_seg[i] = '0;
      end else begin
         e_vld = 0; e_err = 0;
         if (st == 1 && m - last == TMO) begin e_err = 1; st = 0; end
         if (pa_v && pa[5:0] != 6'h3F) begin
            nz = 0; kk = 0;
            for (int i = 0; i < 6; i++) if (!pa[i]) begin nz++; kk = i; end
            if (st == 0) begin
               if (nz == 1 && kk == 0) begin m_seg[0] = pa[13:7]; m_dp[0] = pa[6]; ek = 1; st = 1; last = m; end
            end else if (nz == 1 && kk == ek) begin
               m_seg[kk] = pa[13:7]; m_dp[kk] = pa[6]; last = m;
               if (kk == 5) begin
                  st = 0; e_vld = 1; e_dp = m_dp;
                  for (int i = 0; i < 6; i++) begin
                     e_seg[7*i +: 7] = m_seg[i];
                     e_num[4*i +: 4] = ref_dec(m_seg[i]);
                  end
               end else ek++;
            end else begin
               e_err = 1;
               if (nz == 1 && kk == 0) begin m_seg[0] = pa[13:7]; m_dp[0] = pa[6]; ek = 1; last = m; end
               else st = 0;
            end
         end
         pa_v = pb_v; pa = pb;
         x = {i_seg, i_seg_dp, i_seg_enb};
         rl = (x == lastx) ? (rl <= SETTLE ? rl + 1 : rl) : 1;
         lastx = x;
         pb_v = rl == SETTLE; pb = x;
      end
   end

   always @(negedge clk) begin
      chk("vld", o_frame_vld, e_vld);
      chk("err", o_frm_err, e_err);
      chk("num", o_six_num, e_num);
      chk("dp", o_six_dp, e_dp);
      chk("seg", o_six_digit_seg, e_seg);
      if (o_frame_vld) nv++;
      if (o_frm_err) ne++;
   end

   logic [6:0] fs [6];
   logic [5:0] fdp;
   int nv0, ne0, at, seen;

   task automatic put(input int k, input logic [6:0] s, input logic d, input int n);
      i_seg_enb = (k < 0) ? 6'h3F : ~(6'd1 << k);
      i_seg = s;
      i_seg_dp = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic putraw(input logic [5:0] e, input logic [6:0] s, input logic d, input int n);
      i_seg_enb = e; i_seg = s; i_seg_dp = d;
      repeat (n) @(negedge clk);
   endtask

   task automatic rand_frame();
      for (int k = 0; k < 6; k++) fs[k] = pat[$urandom_range(0, 9)];
      fdp = 6'($urandom);
   endtask

   task automatic scan();
      for (int k = 0; k < 6; k++) put(k, fs[k], fdp[k], 10);
      put(-1, 7'h00, 1'b0, 4);
   endtask

   function automatic logic [41:0] xseg();
      xseg = '0;
      for (int k = 0; k < 6; k++) xseg[7*k +: 7] = fs[k];
   endfunction

   function automatic logic [23:0] xnum();
      xnum = '0;
      for (int k = 0; k < 6; k++) xnum[4*k +: 4] = ref_dec(fs[k]);
   endfunction

   task automatic snap();
      nv0 = nv; ne0 = ne;
   endtask

   initial begin
      rst = 1'b1;
      i_seg = 7'($urandom); i_seg_dp = 1'($urandom); i_seg_enb = 6'($urandom);
      repeat (3) begin
         @(negedge clk);
         i_seg = 7'($urandom); i_seg_dp = 1'($urandom); i_seg_enb = 6'($urandom);
      end
      chk("rst_num", o_six_num, 24'hFFFFFF);
      chk("rst_seg", o_six_digit_seg, 42'h0);
      chk("rst_dp", o_six_dp, 6'h0);
      rst = 1'b0;
      snap();
      put(-1, 7'h00, 1'b0, 8);
      chk("quiet_after_rst", (nv - nv0) + (ne - ne0), 0);

      fs = '{7'h70, 7'h79, 7'h70, 7'h79, 7'h70, 7'h79};
      fdp = 6'b000100;
      snap();
      scan();
      chk("f1_vld_cnt", nv - nv0, 1);
      chk("f1_num", o_six_num, 24'h373737);
      chk("f1_dp", o_six_dp, 6'b000100);
      chk("f1_seg", o_six_digit_seg, xseg());

      rand_frame();
      snap();
      for (int k = 0; k < 6; k++) begin
         if (k == 2) begin
            put(2, fs[2], fdp[2], 2);
            put(2, 7'h00, fdp[2], 2);
            put(2, fs[2], fdp[2], 8);
         end else put(k, fs[k], fdp[k], 10);
      end
      put(-1, 7'h00, 1'b0, 4);
      chk("glitch_vld_cnt", nv - nv0, 1);
      chk("glitch_err_cnt", ne - ne0, 0);
      chk("glitch_num", o_six_num, xnum());
      chk("glitch_dp", o_six_dp, fdp);

      snap();
      put(0, pat[1], 1'b0, 10);
      put(1, pat[2], 1'b0, 10);
      put(3, pat[4], 1'b0, 10);
      put(-1, 7'h00, 1'b0, 4);
      chk("skip_err_cnt", ne - ne0, 1);
      chk("skip_vld_cnt", nv - nv0, 0);
      rand_frame();
      snap();
      scan();
      chk("after_skip_vld", nv - nv0, 1);
      chk("after_skip_num", o_six_num, xnum());

      snap();
      put(0, pat[5], 1'b1, 10);
      i_seg_enb = 6'b111101; i_seg = pat[6];
      at = 0; seen = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (o_frm_err) begin seen++; at = i; end
      end
      chk("tmo_pulses", seen, 1);
      chk("tmo_at", at, SETTLE + 1 + TMO + 1);
      put(-1, 7'h00, 1'b0, 4);
      put(0, pat[7], 1'b0, 10);
      putraw(6'b111100, pat[8], 1'b0, 10);
      put(-1, 7'h00, 1'b0, 4);
      chk("tmo_illegal_err_cnt", ne - ne0, 2);
      chk("tmo_illegal_vld_cnt", nv - nv0, 0);

      rand_frame();
      fs[2] = 7'h01;
      snap();
      scan();
      chk("bad_pat_vld", nv - nv0, 1);
      chk("bad_pat_nib2", o_six_num[11:8], 4'hF);
      chk("bad_pat_num", o_six_num, xnum());

      rand_frame();
      snap();
      for (int k = 0; k < 3; k++) put(k, fs[k], fdp[k], 10);
      put(3, fs[3], fdp[3], 3);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_num", o_six_num, 24'hFFFFFF);
      chk("midrst_seg", o_six_digit_seg, 42'h0);
      chk("midrst_dp", o_six_dp, 6'h0);
      rst = 1'b0;
      for (int k = 3; k < 6; k++) put(k, fs[k], fdp[k], 10);
      put(-1, 7'h00, 1'b0, 4);
      chk("midrst_vld_cnt", nv - nv0, 0);
      chk("midrst_num_hold", o_six_num, 24'hFFFFFF);

      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 7) != 0)
               put(k, 7'($urandom), 1'($urandom), $urandom_range(3, 12));
         end
         if ($urandom_range(0, 1) == 1) put(-1, 7'($urandom), 1'b0, $urandom_range(1, 6));
      end
      put(-1, 7'h00, 1'b0, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
